// File: rtl/tff_ctrl_pkg.sv
// rtl/tff_ctrl_pkg.sv - shared types and defaults for the T flip-flop counter controller
package tff_ctrl_pkg;

  localparam int TFF_WIDTH  = 4;
  localparam int TFF_STEP_W = 8;

  typedef enum logic [1:0] {
    OP_UP  = 2'b00,
    OP_DN  = 2'b01,
    OP_CLR = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with asynchronous active-high reset
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)    q <= 1'b0;
    else if (t) q <= ~q;
  end

  assign q_bar = ~q;

endmodule

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - command-driven up/down counter sequencing a T flip-flop bank
// Build option TFF_CTRL_WRAP_EN: wrap modulo 2^WIDTH with tc; otherwise saturate with sat.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH  = TFF_WIDTH,
  parameter int STEP_W = TFF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  count_n,
  output logic              done,
  output logic              sat,
  output logic              aborted,
  output logic              tc
);

  state_e            state, state_nx;
  op_e               op_q, op_nx;
  logic [STEP_W-1:0] remaining, remaining_nx;
  logic              done_nx, sat_nx, aborted_nx, tc_nx;
  logic [WIDTH-1:0]  t, tv_up, tv_dn, tv_step;
  logic              accept, wrap_step;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Prefix AND/NOR chains: a bit toggles when every lower bit is at the carry/borrow value.
  always_comb begin
    logic up_run, dn_run;
    up_run = 1'b1;
    dn_run = 1'b1;
    tv_up  = '0;
    tv_dn  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tv_up[i] = up_run;
      tv_dn[i] = dn_run;
      up_run   = up_run & count[i];
      dn_run   = dn_run & ~count[i];
    end
  end

  assign tv_step   = (op_q == OP_UP) ? tv_up : (op_q == OP_DN) ? tv_dn : '0;
  assign wrap_step = (op_q == OP_UP) ? (&count) : (op_q == OP_DN) ? (~|count) : 1'b0;

  always_comb begin
    state_nx     = state;
    op_nx        = op_q;
    remaining_nx = remaining;
    t            = '0;
    done_nx      = 1'b0;
    sat_nx       = 1'b0;
    aborted_nx   = 1'b0;
    tc_nx        = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          op_nx = op_e'(cmd_op);
          case (op_e'(cmd_op))
            OP_UP, OP_DN: begin
              if (cmd_steps != '0) begin
                state_nx     = S_RUN;
                remaining_nx = cmd_steps;
              end else begin
                done_nx = 1'b1;
              end
            end
            OP_CLR:  state_nx = S_RUN;
            default: done_nx  = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nx     = S_IDLE;
          remaining_nx = '0;
          done_nx      = 1'b1;
          aborted_nx   = 1'b1;
        end else if (op_q == OP_CLR) begin
          // Toggling every set bit lands the bank on zero in one edge.
          t        = count;
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
`ifdef TFF_CTRL_WRAP_EN
          t            = tv_step;
          tc_nx        = wrap_step;
          remaining_nx = remaining - STEP_W'(1);
          if (remaining == STEP_W'(1)) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
`else
          if (wrap_step) begin
            state_nx     = S_IDLE;
            remaining_nx = '0;
            done_nx      = 1'b1;
            sat_nx       = 1'b1;
          end else begin
            t            = tv_step;
            remaining_nx = remaining - STEP_W'(1);
            if (remaining == STEP_W'(1)) begin
              state_nx = S_IDLE;
              done_nx  = 1'b1;
            end
          end
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      remaining <= '0;
      done      <= 1'b0;
      sat       <= 1'b0;
      aborted   <= 1'b0;
      tc        <= 1'b0;
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      remaining <= remaining_nx;
      done      <= done_nx;
      sat       <= sat_nx;
      aborted   <= aborted_nx;
      tc        <= tc_nx;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .t     (t[i]),
      .q     (count[i]),
      .q_bar (count_n[i])
    );
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - scoreboard bench for tff_count_ctrl (WIDTH=4, STEP_W=8)
module tb_tff_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b11;
  logic [7:0] cmd_steps = 8'h00;
  logic       abort = 1'b0;
  logic [3:0] count, count_n;
  logic       done, sat, aborted, tc;

  tff_count_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .count     (count),
    .count_n   (count_n),
    .done      (done),
    .sat       (sat),
    .aborted   (aborted),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] c;
    logic       r, d, s, a, t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [1:0] UP = 2'b00, DN = 2'b01, CLR = 2'b10, NOP = 2'b11;

`ifdef TFF_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  task automatic push(string tag, logic [3:0] c, logic r, logic d,
                      logic s = 1'b0, logic a = 1'b0, logic t = 1'b0);
    exp_t e;
    e.tag = tag; e.c = c; e.r = r; e.d = d; e.s = s; e.a = a; e.t = t;
    sb.push_back(e);
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_front();
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_mis++;
      $error("FAIL sb_empty observed=%0d expected=>0", sb.size());
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".count"},   count,   e.c);
    chk({e.tag, ".count_n"}, count_n, ~e.c);
    chk({e.tag, ".ready"},   {3'b0, cmd_ready}, {3'b0, e.r});
    chk({e.tag, ".done"},    {3'b0, done},      {3'b0, e.d});
    chk({e.tag, ".sat"},     {3'b0, sat},       {3'b0, e.s});
    chk({e.tag, ".aborted"}, {3'b0, aborted},   {3'b0, e.a});
    chk({e.tag, ".tc"},      {3'b0, tc},        {3'b0, e.t});
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_front();
  endtask

  task automatic send(logic [1:0] op, logic [7:0] steps);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = steps;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_steps = 8'h00;
    check_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    push("reset", 4'h0, 1, 0);
    check_front();
    rst = 1'b0;

    // Zero-step UP and NOP: done on accept, ready stays high
    push("up0_acc", 4'h0, 1, 1); send(UP, 8'h00);
    push("up0_idle", 4'h0, 1, 0); cycle();
    push("nop_acc", 4'h0, 1, 1); send(NOP, 8'h05);
    push("nop_idle", 4'h0, 1, 0); cycle();

    // UP 3 from 0
    push("up3_k", 4'h0, 0, 0); send(UP, 8'd3);
    push("up3_k1", 4'h1, 0, 0); cycle();
    push("up3_k2", 4'h2, 0, 0); cycle();
    push("up3_k3", 4'h3, 1, 1); cycle();
    push("up3_k4", 4'h3, 1, 0); cycle();

    // UP 7 from 3 to reach 4'hA
    push("up7_k", 4'h3, 0, 0); send(UP, 8'd7);
    for (int i = 1; i <= 6; i++) begin
      push("up7_run", 4'(3 + i), 0, 0); cycle();
    end
    push("up7_done", 4'hA, 1, 1); cycle();

    // CLR from 4'hA, cmd_steps ignored
    push("clr_k", 4'hA, 0, 0); send(CLR, 8'hFF);
    push("clr_k1", 4'h0, 1, 1); cycle();
    push("clr_k2", 4'h0, 1, 0); cycle();

    // DN 2 from 0: wrap with tc, or saturate with sat
    push("dn2_k", 4'h0, 0, 0); send(DN, 8'd2);
    if (WRAP) begin
      push("dn2_wrap1", 4'hF, 0, 0, 0, 0, 1); cycle();
      push("dn2_wrap2", 4'hE, 1, 1); cycle();
    end else begin
      push("dn2_sat", 4'h0, 1, 1, 1); cycle();
    end
    push("dn2_idle", WRAP ? 4'hE : 4'h0, 1, 0); cycle();

    // Back to 0
    push("clr2_k", WRAP ? 4'hE : 4'h0, 0, 0); send(CLR, 8'h00);
    push("clr2_k1", 4'h0, 1, 1); cycle();

    // Abort on the last step of UP 4, then a back-to-back command
    push("ab_k", 4'h0, 0, 0); send(UP, 8'd4);
    push("ab_k1", 4'h1, 0, 0); cycle();
    push("ab_k2", 4'h2, 0, 0); cycle();
    push("ab_k3", 4'h3, 0, 0); cycle();
    abort = 1'b1;
    push("ab_k4", 4'h3, 1, 1, 0, 1); cycle();
    abort = 1'b0;
    push("b2b_k", 4'h3, 0, 0); send(UP, 8'd1);
    push("b2b_k1", 4'h4, 1, 1); cycle();

    // Abort while idle is ignored
    abort = 1'b1;
    push("ab_idle", 4'h4, 1, 0); cycle();
    abort = 1'b0;

    // Reset mid-command at count 5
    push("clr3_k", 4'h4, 0, 0); send(CLR, 8'h00);
    push("clr3_k1", 4'h0, 1, 1); cycle();
    push("mid_k", 4'h0, 0, 0); send(UP, 8'd8);
    for (int i = 1; i <= 5; i++) begin
      push("mid_run", 4'(i), 0, 0); cycle();
    end
    #2 rst = 1'b1;
    #1;
    push("mid_rst", 4'h0, 1, 0);
    check_front();
    @(negedge clk);
    rst = 1'b0;
    push("post_rst", 4'h0, 1, 0); cycle();

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_mis++;
      $error("FAIL sb_left observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Command-driven controller that sequences a bank of WIDTH T flip-flops as a synchronous up/down counter. Each accepted command computes the per-bit toggle vector every cycle and applies it for the requested number of steps. The block sits between a command source and the flop bank, which it instantiates internally. It owns all `t` inputs, so no other logic may toggle the bank.

## Interface
- WIDTH, 4, number of T flip-flop cells in the bank (≥2)
- STEP_W, 8, width of the step-count field
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_op  input  2  operation: UP=2'b00, DN=2'b01, CLR=2'b10, NOP=2'b11
- cmd_steps  input  STEP_W  number of count steps (UP/DN only)
- abort  input  1  terminate a running command
- count  output  WIDTH  bank `q` outputs
- count_n  output  WIDTH  bank `q_bar` outputs; always ~count
- done  output  1  one-cycle pulse at command completion
- sat  output  1  qualifies done: stopped at a limit (only without wrap)
- aborted  output  1  qualifies done: ended by abort
- tc  output  1  one-cycle pulse when a step wraps the count (only with wrap)

## Operation
- States: IDLE, RUN.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_op and cmd_steps are captured on that edge.
- IDLE + accept UP/DN with cmd_steps>0: go to RUN; remaining=cmd_steps; direction latched.
- IDLE + accept UP/DN with cmd_steps==0, or NOP: stay in IDLE; done pulses on the accept edge; count is unchanged.
- IDLE + accept CLR: go to RUN for one cycle with t=count. The bank reaches 0 on the next edge and done pulses; cmd_steps is ignored.
- Toggle vector in RUN:
  - UP: t[0]=1, t[i]=&count[i-1:0].
  - DN: t[0]=1, t[i]=&~count[i-1:0].
  - Otherwise t=0.
- Each RUN edge applies one step and decrements remaining. When remaining reaches 0: return to IDLE and pulse done.
- abort in RUN: t=0 on that edge; return to IDLE; done=1 and aborted=1. abort has priority over the final step, which is then not applied. abort in IDLE is ignored.
- sat, aborted and tc are valid only while done (tc is its own pulse) and are 0 otherwise.
- Reset, at any time including mid-command:
  - count=0, count_n=all ones.
  - state=IDLE, so cmd_ready=1.
  - done=0, sat=0, aborted=0, tc=0.
  - remaining=0.

## Timing
- Accept at edge k with N steps: count updates at edges k+1..k+N.
- done is registered high for the cycle following edge k+N.
- cmd_ready returns high after edge k+N. A new command can be accepted on edge k+N+1, so there is one dead cycle between commands.
- CLR: count=0 after edge k+1; done during the following cycle.
- cmd_ready is combinational from state only, never from cmd_valid.
- tc pulses during the cycle after the wrapping edge: 1…1→0…0 for UP, 0…0→1…1 for DN.

## Configuration
- TFF_CTRL_WRAP_EN defined:
  - The counter wraps modulo 2^WIDTH and tc pulses on each wrap.
  - sat is tied 0.
- TFF_CTRL_WRAP_EN undefined:
  - A step that would wrap is suppressed (t=0 on that edge), the command terminates, and done and sat pulse together.
  - Saturation points: UP at all ones, DN at 0.
  - tc is tied 0.

## Structure
- Package tff_ctrl_pkg holds:
  - op enum (OP_UP, OP_DN, OP_CLR, OP_NOP) with the encodings above;
  - state enum (S_IDLE, S_RUN);
  - default constants for WIDTH and STEP_W.
- Sub-module tff_cell: a single T flip-flop with asynchronous active-high reset to q=0 and q_bar=~q. It is instantiated WIDTH times in a generate loop.
- The controller FSM, remaining counter and toggle-vector logic live in tff_count_ctrl.

## Test plan
- Reset mid-command: assert rst while count=4'h5 in RUN → count=0, count_n=4'hF, cmd_ready=1 and done=0, all asynchronously.
- UP with 3 steps from 0: count goes 1, 2, 3 on edges k+1..k+3; done pulses for exactly one cycle after k+3; cmd_ready is low for 3 cycles.
- DN with 2 steps from 0:
  - With wrap: count F then E, and tc pulses once after the first step.
  - Without wrap: count stays 0, done and sat pulse after edge k+1.
- abort on the last step of UP with 4 steps from 0: count stays 3; done=1 with aborted=1; a back-to-back cmd_valid is accepted one cycle later.
- CLR from count=4'hA → count=0 after one edge; done pulses; cmd_steps=8'hFF is ignored.
- UP with 0 steps and NOP → done pulses on the accept edge with no count change; cmd_ready stays high throughout.
